// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the unified memory.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// data first, with a starvation counter that eventually forces a fetch grant.
//
// state    | meaning
// S_IDLE   | sample requests, pick a winner, latch the access
// S_ACCESS | mem_en high for one cycle
// S_WAIT   | count down the read latency, capture read data on the last cycle
// S_DONE   | owner's ack high for one cycle
module unified_mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data port owns the current access
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          fetch_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_win   = bus.if_req && (!bus.d_req || (starve_q == SW'(STARVE_MAX)));

    case (state_q)
      S_IDLE: begin
        if (!bus.if_req) starve_d = '0;
        if (bus.if_req || bus.d_req) begin
          state_d  = S_ACCESS;
          mem_en_d = 1'b1;
          if (fetch_win) begin
            owner_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = 1'b1;
            mem_we_d    = bus.d_we;
            mem_be_d    = bus.d_we ? bus.d_be : 4'hF;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (bus.if_req && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
          end
        end
      end
      S_ACCESS: begin
        if (mem_we_q) begin
          state_d  = S_DONE;
          d_ack_d  = owner_q;
          if_ack_d = !owner_q;
        end else begin
          cnt_d   = CW'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // mem_rdata is valid in the cycle the counter sits at 1
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (owner_q) begin
            d_rdata_d = bus.mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a two-stage-latency memory model.
module tb_unified_mem_arbiter;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.LATENCY(LATENCY), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: read data appears in the second cycle after the mem_en cycle, junk otherwise.
  logic [31:0] mem_arr [256];
  logic [31:0] rd_stage;
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
      mem_arr[8'h04] <= 32'h00500093;
      mem_arr[8'h05] <= 32'h00A00113;
      mem_ready <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem_arr[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    rd_stage      <= (bus.mem_en && !bus.mem_we) ? mem_arr[bus.mem_addr[9:2]] : 32'hBAD0BAD0;
    bus.mem_rdata <= rd_stage;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  task automatic test_reset();
    logic [136:0] outs;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = $urandom;
      bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1));
      bus.d_be = 4'($urandom); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      tick();
      outs = {bus.if_rdata, bus.if_ack, bus.d_rdata, bus.d_ack, bus.mem_en, bus.mem_we,
              bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.busy};
      checks++;
      if (outs !== '0) $display("FAIL reset_outputs cycle %0d: got %h want 0", c, outs);
      else passed++;
    end
    clear_inputs();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.mem_en, bus.busy, bus.if_ack, bus.d_ack} !== 4'b0)
        $display("FAIL reset_release_idle cycle %0d: got %b want 0000", c,
                 {bus.mem_en, bus.busy, bus.if_ack, bus.d_ack});
      else passed++;
    end
  endtask

  task automatic test_single_fetch();
    bus.if_req = 1; bus.if_addr = 32'h10;
    tick();  // cycle 1
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.busy} !== {1'b1, 1'b0, 4'hF, 32'h10, 1'b1})
      $display("FAIL fetch_access: got en=%b we=%b be=%h addr=%h busy=%b want 1 0 f 00000010 1",
               bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.busy);
    else passed++;
    tick();  // cycle 2
    tick();  // cycle 3
    checks++;
    if ({bus.mem_en, bus.if_ack} !== 2'b00)
      $display("FAIL fetch_wait: got en=%b ack=%b want 0 0", bus.mem_en, bus.if_ack);
    else passed++;
    tick();  // cycle 4
    checks++;
    if ({bus.if_ack, bus.d_ack, bus.if_rdata} !== {1'b1, 1'b0, 32'h00500093})
      $display("FAIL fetch_ack: got if_ack=%b d_ack=%b rdata=%h want 1 0 00500093",
               bus.if_ack, bus.d_ack, bus.if_rdata);
    else passed++;
    bus.if_req = 0;
    tick();  // cycle 5
    checks++;
    if ({bus.if_ack, bus.busy, bus.if_rdata} !== {1'b0, 1'b0, 32'h00500093})
      $display("FAIL fetch_after: got ack=%b busy=%b rdata=%h want 0 0 00500093",
               bus.if_ack, bus.busy, bus.if_rdata);
    else passed++;
  endtask

  task automatic test_simultaneous();
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0010; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
    bus.if_req = 1; bus.if_addr = 32'h14;
    tick();  // cycle 1
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 4'b0010, 32'h100, 32'hDEADBEEF})
      $display("FAIL store_access: got en=%b we=%b be=%h addr=%h wdata=%h want 1 1 2 00000100 deadbeef",
               bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    else passed++;
    tick();  // cycle 2
    checks++;
    if ({bus.d_ack, bus.if_ack, bus.mem_en} !== 3'b100)
      $display("FAIL store_ack: got d_ack=%b if_ack=%b en=%b want 1 0 0", bus.d_ack, bus.if_ack, bus.mem_en);
    else passed++;
    bus.d_req = 0;
    tick();  // cycle 3
    checks++;
    if ({bus.mem_en, bus.busy, bus.d_ack, bus.mem_addr, bus.mem_be} !== {3'b000, 32'h100, 4'b0010})
      $display("FAIL idle_gap: got en=%b busy=%b d_ack=%b addr=%h be=%h want 0 0 0 00000100 2",
               bus.mem_en, bus.busy, bus.d_ack, bus.mem_addr, bus.mem_be);
    else passed++;
    tick();  // cycle 4
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h14})
      $display("FAIL fetch_follow: got en=%b we=%b be=%h addr=%h want 1 0 f 00000014",
               bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr);
    else passed++;
    tick();  // cycle 5
    checks++;
    if ({bus.mem_en, bus.mem_addr, bus.mem_be} !== {1'b0, 32'h14, 4'hF})
      $display("FAIL addr_stable: got en=%b addr=%h be=%h want 0 00000014 f", bus.mem_en, bus.mem_addr, bus.mem_be);
    else passed++;
    tick();  // cycle 6
    tick();  // cycle 7
    checks++;
    if ({bus.if_ack, bus.d_ack, bus.if_rdata} !== {1'b1, 1'b0, 32'h00A00113})
      $display("FAIL fetch_follow_ack: got if_ack=%b d_ack=%b rdata=%h want 1 0 00a00113",
               bus.if_ack, bus.d_ack, bus.if_rdata);
    else passed++;
    bus.if_req = 0;
    tick();
  endtask

  task automatic test_load_after_store();
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'b0000; bus.d_addr = 32'h100;
    tick();  // cycle 1
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("FAIL load_access: got en=%b we=%b be=%h addr=%h want 1 0 f 00000100",
               bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr);
    else passed++;
    tick(); tick(); tick();  // cycle 4
    checks++;
    if ({bus.d_ack, bus.if_ack, bus.d_rdata, bus.if_rdata} !== {1'b1, 1'b0, 32'h0000BE00, 32'h00A00113})
      $display("FAIL load_data: got d_ack=%b if_ack=%b d_rdata=%h if_rdata=%h want 1 0 0000be00 00a00113",
               bus.d_ack, bus.if_ack, bus.d_rdata, bus.if_rdata);
    else passed++;
    bus.d_req = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_d = 10'b0111101111;  // bit i = 1 when grant i goes to data
    int grants = 0, n_dack = 0, n_iack = 0, both = 0, last_en = -1, cyc = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.if_req = 1; bus.if_addr = 32'h10;
    while ((grants < 10 || (n_dack + n_iack) < 10) && cyc < 300) begin
      tick();
      cyc++;
      if (bus.mem_en) begin
        if (grants < 10) begin
          checks++;
          if ((bus.mem_addr == 32'h100) !== exp_d[grants])
            $display("FAIL starve_order grant %0d: got data=%b want %b", grants, bus.mem_addr == 32'h100, exp_d[grants]);
          else passed++;
        end
        if (last_en >= 0) begin
          checks++;
          if (cyc - last_en != LATENCY + 3)
            $display("FAIL read_spacing grant %0d: got %0d want %0d", grants, cyc - last_en, LATENCY + 3);
          else passed++;
        end
        last_en = cyc;
        grants++;
        if (grants == 10) begin bus.d_req = 0; bus.if_req = 0; end
      end
      if (bus.d_ack) begin
        n_dack++;
        checks++;
        if (bus.d_rdata !== 32'h0000BE00) $display("FAIL starve_d_rdata: got %h want 0000be00", bus.d_rdata);
        else passed++;
      end
      if (bus.if_ack) begin
        n_iack++;
        checks++;
        if (bus.if_rdata !== 32'h00500093) $display("FAIL starve_if_rdata: got %h want 00500093", bus.if_rdata);
        else passed++;
      end
      if (bus.d_ack && bus.if_ack) both++;
    end
    checks++;
    if (cyc >= 300) $display("FAIL starve_timeout: got %0d grants %0d acks want 10 10", grants, n_dack + n_iack);
    else passed++;
    checks++;
    if ({n_dack, n_iack, both} !== {32'd8, 32'd2, 32'd0})
      $display("FAIL starve_ack_counts: got d=%0d if=%0d both=%0d want 8 2 0", n_dack, n_iack, both);
    else passed++;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_read();
    int stray = 0;
    bus.if_req = 1; bus.if_addr = 32'h14;
    tick();  // cycle 1
    checks++;
    if (bus.mem_en !== 1'b1) $display("FAIL abort_access: got en=%b want 1", bus.mem_en);
    else passed++;
    tick();  // cycle 2, in WAIT
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_en, bus.if_ack, bus.d_ack, bus.busy, bus.if_rdata} !== '0)
      $display("FAIL abort_reset: got en=%b if_ack=%b d_ack=%b busy=%b if_rdata=%h want all 0",
               bus.mem_en, bus.if_ack, bus.d_ack, bus.busy, bus.if_rdata);
    else passed++;
    bus.if_req = 0;
    tick(); tick();
    rst = 1'b1;
    repeat (6) begin
      tick();
      if (bus.if_ack || bus.d_ack || bus.mem_en) stray++;
    end
    checks++;
    if (stray != 0) $display("FAIL abort_no_ack: got %0d stray cycles want 0", stray);
    else passed++;
    bus.if_req = 1;
    tick();  // cycle 1
    checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h14})
      $display("FAIL reissue_access: got en=%b addr=%h want 1 00000014", bus.mem_en, bus.mem_addr);
    else passed++;
    tick(); tick(); tick();  // cycle 4
    checks++;
    if ({bus.if_ack, bus.if_rdata} !== {1'b1, 32'h00A00113})
      $display("FAIL reissue_ack: got ack=%b rdata=%h want 1 00a00113", bus.if_ack, bus.if_rdata);
    else passed++;
    bus.if_req = 0;
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_load_after_store();
    test_starvation();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequencing controller that shares one single-ported unified instruction/data memory between the CPU's instruction-fetch path and its load/store path. Each requester holds a req/ack handshake. The block picks a winner, drives exactly one memory access, waits out the fixed memory read latency, and returns read data with a one-cycle ack. Data accesses have priority; a starvation counter guarantees forward progress for fetch. It sits between the CPU core and the memory model inside the CPU top level.

## Interface
- LATENCY, 2: memory read latency in cycles (≥1). mem_rdata is valid LATENCY cycles after the edge that samples mem_en.
- STARVE_MAX, 4: consecutive data grants allowed while if_req is pending before fetch is forced (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word, valid while if_ack=1, held otherwise.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_be  in  4  store byte enables.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data. Updated only on loads; held otherwise.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe, high for exactly one cycle per access.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_be  out  4  byte enables; 4'hF on reads.
- mem_addr  out  32  access address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- All outputs are registered. With rst=0, every output is 0 and state=IDLE.
- State IDLE
  - If neither request is active, stay in IDLE.
  - Otherwise select a winner, latch owner, addr, we, be and wdata into the mem_* registers, and go to ACCESS.
  - A fetch winner always gets mem_we=0 and mem_be=4'hF.
- Winner rule
  - Only d_req active: data wins.
  - Only if_req active: fetch wins.
  - Both active: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, and clears in IDLE when if_req=0.
  - Saturates at STARVE_MAX.
- State ACCESS
  - Lasts one cycle with mem_en=1.
  - Write: go to DONE.
  - Read: load wait counter with LATENCY and go to WAIT.
- State WAIT
  - Decrement the counter each cycle.
  - On the cycle where the counter reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
- State DONE
  - Assert the owner's ack for exactly one cycle, then go to IDLE.
  - The non-owner's ack and rdata are unchanged.
- Requests are sampled only in IDLE. A requester that keeps req high after its ack is treated as issuing a new request.
- mem_addr, mem_be and mem_wdata hold their values after ACCESS until the next grant. They are don't-care when mem_en=0, but the bench checks that they are stable.
- Asynchronous reset mid-transaction (any state) aborts it: no ack is issued and starve_cnt clears. The requester must re-issue.

## Timing
- Request asserted in cycle 0 (sampled at the end of cycle 0, state IDLE):
  - mem_en is high in cycle 1.
  - Write: ack in cycle 2.
  - Read: ack in cycle LATENCY+2, with rdata equal to mem_rdata from cycle LATENCY+1.
- Back-to-back grants always pass through one IDLE cycle.
  - Minimum spacing of mem_en pulses: 3 cycles for writes, LATENCY+3 cycles for reads.
- if_ack and d_ack are never high in the same cycle. Exactly one mem_en pulse occurs per ack.
- Input requests are not combinationally passed to any output.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0 and busy=0. Release rst → still idle with no stray mem_en.
- Single fetch, LATENCY=2:
  - Stimulus: if_req with if_addr=0x10 in cycle 0; memory returns 0x00500093.
  - Response: mem_en=1, mem_we=0, mem_addr=0x10 in cycle 1; if_ack=1 with if_rdata=0x00500093 in cycle 4.
- Simultaneous requests in cycle 0: store to 0x100 with data 0xDEADBEEF and be=4'b0010, plus fetch at 0x14.
  - Data wins: mem_we=1 and mem_be=4'b0010 in cycle 1; d_ack in cycle 2.
  - Fetch follows: mem_en in cycle 4; if_ack in cycle 7.
- Starvation, STARVE_MAX=4: hold d_req and if_req high continuously with loads → grant order D,D,D,D,F,D,D,D,D,F…; ack counts match grants.
- Reset mid-read: drive rst=0 during WAIT → mem_en, if_ack and d_ack are 0 immediately, and no ack follows release. A re-issued request completes at nominal latency.
- Load after store to the same address 0x100 → d_rdata=0xDEADBEEF masked by be, and if_rdata is unchanged.
